// File: rtl/johnson_step_sequencer_if.sv
// Command channel of the Johnson step sequencer: one move request per valid/ready handshake.
// The master offers a command; the slave accepts it on an edge where cmd_valid and cmd_ready are both high.
interface johnson_step_sequencer_if #(
   parameter int CNT_W = 16,
   parameter int DIV_W = 16
) ();
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_dir;
   logic [CNT_W-1:0] cmd_steps;
   logic [DIV_W-1:0] cmd_div;

   modport master (
      output cmd_valid, cmd_dir, cmd_steps, cmd_div,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_dir, cmd_steps, cmd_div,
      output cmd_ready
   );
endinterface

// File: rtl/johnson_step_sequencer.sv
// Steps a WIDTH-bit Johnson phase register forward or backward by a commanded count,
// one step every (div+1) clocks, and pulses done when the move completes or is aborted.
module johnson_step_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 16,
   parameter int DIV_W = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   johnson_step_sequencer_if.slave     cmd,
   input  logic                        abort,
   output logic [WIDTH-1:0]            phase,
   output logic                        busy,
   output logic                        done,
   output logic                        aborted,
   output logic [CNT_W-1:0]            steps_left
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_phase;
   logic             r_dir;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_div_cnt;
   logic [CNT_W-1:0] r_steps_left;
   logic             r_aborted;

   logic [WIDTH-1:0] w_fwd_next;
   logic [WIDTH-1:0] w_rev_next;
   logic             w_accept;

   assign w_fwd_next = {r_phase[WIDTH-2:0], ~r_phase[WIDTH-1]};
   assign w_rev_next = {~r_phase[0], r_phase[WIDTH-1:1]};
   assign w_accept   = cmd.cmd_valid && (r_state == IDLE);

   // Status outputs are pure decodes of the state register, so reset reaches them without an edge.
   assign cmd.cmd_ready = (r_state == IDLE);
   assign busy          = (r_state != IDLE);
   assign done          = (r_state == DONE);
   assign phase         = r_phase;
   assign aborted       = r_aborted;
   assign steps_left    = r_steps_left;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_phase      <= '0;
         r_dir        <= 1'b0;
         r_div        <= '0;
         r_div_cnt    <= '0;
         r_steps_left <= '0;
         r_aborted    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_aborted <= 1'b0;
                  if (cmd.cmd_steps == '0) begin
                     r_steps_left <= '0;
                     r_state      <= DONE;
                  end else begin
                     r_dir        <= cmd.cmd_dir;
                     r_div        <= cmd.cmd_div;
                     r_div_cnt    <= cmd.cmd_div;
                     r_steps_left <= cmd.cmd_steps;
                     r_state      <= RUN;
                  end
               end
            end

            RUN: begin
               // Abort wins over a due step: position and count freeze where they are.
               if (abort) begin
                  r_aborted <= 1'b1;
                  r_state   <= DONE;
               end else if (r_div_cnt == '0) begin
                  r_phase      <= r_dir ? w_fwd_next : w_rev_next;
                  r_steps_left <= r_steps_left - CNT_W'(1);
                  r_div_cnt    <= r_div;
                  if (r_steps_left == CNT_W'(1)) r_state <= DONE;
               end else begin
                  r_div_cnt <= r_div_cnt - DIV_W'(1);
               end
            end

            DONE: r_state <= IDLE;

            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/johnson_step_sequencer.md
# johnson_step_sequencer

Command-driven controller that sequences a WIDTH-bit Johnson phase register (2*WIDTH states) forward or backward by a programmed number of steps at a programmed rate. It is the stepping engine for phase-pattern outputs such as stepper-motor coil drives and multiphase enables. A host issues one command per move through a valid/ready handshake and receives a one-cycle completion pulse. Position is retained between commands.

## Interface
- WIDTH, 4, Johnson register width; pattern period is 2*WIDTH steps.
- CNT_W, 16, width of the step-count field.
- DIV_W, 16, width of the rate-divider field.

- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  high exactly when state is IDLE; command accepted on an edge with cmd_valid & cmd_ready.
- cmd_dir  input  1  1 = forward, 0 = reverse.
- cmd_steps  input  CNT_W  number of steps to take (0 allowed).
- cmd_div  input  DIV_W  step period minus one, in clk cycles.
- abort  input  1  stops the move in progress.
- phase  output  WIDTH  Johnson phase pattern (registered).
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse at command completion.
- aborted  output  1  registered; valid while done=1, high if the move ended by abort.
- steps_left  output  CNT_W  remaining steps of the current/last command.

## Operation
- Forward step: phase <= {phase[WIDTH-2:0], ~phase[WIDTH-1]}. Reverse step: phase <= {~phase[0], phase[WIDTH-1:1]}.
- Forward from 0000 (WIDTH=4): 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000. Reverse is the exact inverse sequence. Wrap-around is inherent; there is no end stop.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On accept with cmd_steps=0: go to DONE; phase is unchanged; steps_left <= 0.
  - On accept with cmd_steps>0: latch dir and div; steps_left <= cmd_steps; div_cnt <= cmd_div; go to RUN.
  - Abort in IDLE is ignored.
- RUN, each edge:
  - If abort=1: go to DONE and set aborted. No step is taken on that edge, even if div_cnt=0; steps_left and phase hold.
  - Else if div_cnt=0: take one step; steps_left <= steps_left-1; div_cnt <= div. If steps_left was 1, go to DONE.
  - Else: div_cnt <= div_cnt-1.
- DONE: done=1 for exactly this one cycle; next edge goes to IDLE.
- aborted is cleared on every command accept.
- steps_left never wraps, because RUN exits when it reaches 0.
- div=2^DIV_W-1 gives 2^DIV_W cycles per step.
- cmd_valid while busy is not accepted and is not queued; the host must hold it until cmd_ready=1.
- Reset (rst low), at any time including mid-move, takes effect immediately without a clock edge:
  - state=IDLE; phase=0; steps_left=0; div_cnt=0; busy=0; done=0; aborted=0; cmd_ready=1.
  - Any in-flight command is discarded.

## Timing
- Accept edge is E0. Step n (1..cmd_steps) updates phase at edge E0 + n*(cmd_div+1).
- done is high during the cycle following the final-step edge, i.e. from E0 + cmd_steps*(cmd_div+1) for one cycle.
- cmd_ready returns high one edge after that, so back-to-back commands are separated by one DONE cycle.
- Zero-step command: done is high in the cycle after E0; busy is high for 1 cycle.
- Abort sampled at edge Ea: done and aborted are high in the cycle after Ea.
- busy is high from the cycle after E0 through the DONE cycle inclusive.

## Test plan
- Reset: drive rst=0 mid-cycle with no clock edge -> phase=0000, busy=0, done=0, aborted=0, steps_left=0, cmd_ready=1 immediately.
- Forward, steps=3, div=0, from 0000 -> phase 0001, 0011, 0111 on edges E0+1..E0+3; done for one cycle after E0+3; steps_left=0; cmd_ready=1 one cycle later.
- Reverse, steps=2, div=2, from 0111 -> 0011 at E0+3, 0001 at E0+6, done after E0+6. Then forward, steps=8, div=0 -> phase returns to 0001 (wrap).
- steps=0 -> done in the cycle after E0, phase unchanged, busy high for 1 cycle. cmd_valid held during busy -> no second accept until cmd_ready=1.
- Abort, steps=5, div=3: abort asserted right after the 2nd step -> done=1, aborted=1, steps_left=3, phase holds. Abort coincident with a div_cnt=0 edge -> no step on that edge.
- rst pulled low mid-move (steps=10, div=1, after 4 steps) -> all outputs reset asynchronously. After rst high, a new command starts from phase 0000.
